// File: rtl/led_pkg.sv
// Shared types and defaults for the LED blink driver.
// Binary-encoded FSM state plus default phase lengths.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } blink_state_t;

  localparam int DEF_ON_CYCLES  = 4;
  localparam int DEF_OFF_CYCLES = 4;

endpackage

// File: rtl/led_blink_driver_phase_timer.sv
// Phase timer: counts up while enabled, flags the terminal count.
// Sync clear restarts the phase from zero.
module phase_timer #(
  parameter int TIMER_W = 22
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic [TIMER_W-1:0] term,
  output logic               expire
);

  logic [TIMER_W-1:0] cnt;

  // Phase counter; clear wins over count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TIMER_W'(1);
    end
  end

  assign expire = en && (cnt == term);

endmodule

// File: rtl/led_blink_driver.sv
// LED blink driver: takes a blink count over valid/ready and
// drives N timed on/off pulses, then a one-cycle done pulse.
module led_blink_driver
  import led_pkg::*;
#(
  parameter int ON_CYCLES  = DEF_ON_CYCLES,
  parameter int OFF_CYCLES = DEF_OFF_CYCLES,
  parameter int NUM_W      = 4,
  parameter int TIMER_W    = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [NUM_W-1:0] cmd_count,
  input  logic             abort,
  output logic             led,
  output logic             busy,
  output logic             done
);

  localparam logic [TIMER_W-1:0] ON_TERM  = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] OFF_TERM = TIMER_W'(OFF_CYCLES - 1);

  blink_state_t       state_q;
  blink_state_t       state_d;
  logic [NUM_W-1:0]   rem_q;
  logic [NUM_W-1:0]   rem_d;
  logic               fin;
  logic               accept;
  logic               expire;
  logic               t_clr;
  logic               t_en;
  logic [TIMER_W-1:0] t_term;
  logic               led_d;
  logic               busy_d;
  logic               done_d;

  assign cmd_ready = rst_n && !abort && (state_q == IDLE);
  assign accept    = cmd_valid && cmd_ready;

  assign t_en   = (state_q != IDLE);
  assign t_clr  = abort || (state_q == IDLE) || expire;
  assign t_term = (state_q == ON) ? ON_TERM : OFF_TERM;

  phase_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (t_clr),
    .en     (t_en),
    .term   (t_term),
    .expire (expire)
  );

  // State and remaining-blink register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state: accept, phase changes, completion and abort.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    fin     = 1'b0;
    if (abort) begin
      state_d = IDLE;
      rem_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (cmd_count == '0) begin
              fin = 1'b1;
            end else begin
              rem_d   = cmd_count;
              state_d = ON;
            end
          end
        end
        ON: begin
          if (expire) state_d = OFF;
        end
        OFF: begin
          if (expire) begin
            if (rem_q > NUM_W'(1)) begin
              rem_d   = rem_q - NUM_W'(1);
              state_d = ON;
            end else begin
              state_d = IDLE;
              fin     = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Output decode from the upcoming state.
  always_comb begin
    led_d  = (state_d == ON);
    busy_d = (state_d != IDLE);
    done_d = fin;
  end

  // Registered outputs, aligned with the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led  <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      led  <= led_d;
      busy <= busy_d;
      done <= done_d;
    end
  end

endmodule

// File: tb/tb_led_blink_driver.sv
// Bench for led_blink_driver: timing-formula reference model
// feeding a scoreboard queue, checked one cycle later.
module tb_led_blink_driver;

  localparam int ON  = 4;
  localparam int OFF = 4;
  localparam int P   = ON + OFF;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_count;
  logic       abort;
  logic       led;
  logic       busy;
  logic       done;

  typedef struct {
    logic led;
    logic busy;
    logic done;
  } exp_t;

  exp_t sb[$];

  int errs;
  int chks;
  int m_active;
  int m_t;
  int m_n;
  int m_done;
  int done_seen;

  led_blink_driver #(
    .ON_CYCLES  (ON),
    .OFF_CYCLES (OFF),
    .NUM_W      (4),
    .TIMER_W    (22)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_count (cmd_count),
    .abort     (abort),
    .led       (led),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle: drive, check ready, advance model, check outputs.
  task automatic cyc(input logic v, input logic [3:0] n,
                     input logic ab, input logic rn);
    exp_t e;
    logic exp_rdy;
    cmd_valid = v;
    cmd_count = n;
    abort     = ab;
    rst_n     = rn;
    #1;
    exp_rdy = (m_active == 0) && !ab && rn;
    chk("cmd_ready", 32'(cmd_ready), 32'(exp_rdy));
    if (!rn || ab) begin
      m_active = 0;
      m_done   = 0;
    end else if (m_active != 0) begin
      m_t++;
      m_done = 0;
      if (m_t == m_n * P) begin
        m_active = 0;
        m_done   = 1;
      end
    end else begin
      m_done = 0;
      if (v) begin
        if (n == 4'd0) begin
          m_done = 1;
        end else begin
          m_active = 1;
          m_t      = 0;
          m_n      = int'(n);
        end
      end
    end
    e.led  = (m_active != 0) && ((m_t % P) < ON);
    e.busy = (m_active != 0);
    e.done = (m_done != 0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("led", 32'(led), 32'(e.led));
    chk("busy", 32'(busy), 32'(e.busy));
    chk("done", 32'(done), 32'(e.done));
    if (done) done_seen++;
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  initial begin
    errs      = 0;
    chks      = 0;
    m_active  = 0;
    m_t       = 0;
    m_n       = 0;
    m_done    = 0;
    done_seen = 0;
    cmd_valid = 1'b0;
    cmd_count = 4'd0;
    abort     = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    cyc(1'b0, 4'd0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0);
    idle(2);

    // count=3: led 1-4, 9-12, 17-20; done at 25
    done_seen = 0;
    cyc(1'b1, 4'd3, 1'b0, 1'b1);
    idle(27);
    chk("done_n_c3", 32'(done_seen), 32'd1);

    // count=0: immediate done, never busy
    done_seen = 0;
    cyc(1'b1, 4'd0, 1'b0, 1'b1);
    idle(3);
    chk("done_n_c0", 32'(done_seen), 32'd1);

    // count=1 then held count=2, accepted in done cycle
    done_seen = 0;
    cyc(1'b1, 4'd1, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) cyc(1'b1, 4'd2, 1'b0, 1'b1);
    idle(19);
    chk("done_n_b2b", 32'(done_seen), 32'd2);

    // count=5 aborted in cycle 10
    done_seen = 0;
    cyc(1'b1, 4'd5, 1'b0, 1'b1);
    idle(9);
    cyc(1'b0, 4'd0, 1'b1, 1'b1);
    idle(45);
    chk("done_n_abort", 32'(done_seen), 32'd0);

    // reset in cycle 6 of count=2, with cmd_valid present
    done_seen = 0;
    cyc(1'b1, 4'd2, 1'b0, 1'b1);
    idle(5);
    cyc(1'b1, 4'd3, 1'b0, 1'b0);
    idle(20);
    chk("done_n_rst", 32'(done_seen), 32'd0);

    // abort and valid together while idle
    done_seen = 0;
    cyc(1'b1, 4'd2, 1'b1, 1'b1);
    idle(6);
    chk("done_n_abidle", 32'(done_seen), 32'd0);

    // max count 15
    done_seen = 0;
    cyc(1'b1, 4'd15, 1'b0, 1'b1);
    idle(15 * P + 2);
    chk("done_n_c15", 32'(done_seen), 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
